cpu_bus_if: RTL and testbench
=============================

CPU_BUS_IF -- requirements
Module: cpu_bus_if

Interface
REQ-001 Parameter TIMEOUT, default 8, max ACCESS cycles before forced completion; legal range 1..255.
REQ-002 clk  input  1  single system clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-004 cpu_en  input  1  CPU step enable; qualifies new requests only.
REQ-005 req  input  1  CPU bus request from control unit.
REQ-006 we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  input  16  CPU address; sampled with req.
REQ-008 wdata  input  8  write data; sampled with req.
REQ-009 mem_addr  output  16  registered address to memory map.
REQ-010 mem_wdata  output  8  registered write data.
REQ-011 mem_re  output  1  read strobe, held until completion.
REQ-012 mem_we  output  1  write strobe, held until completion.
REQ-013 mem_rdata  input  8  memory read data, valid when mem_ready=1.
REQ-014 mem_ready  input  1  memory completion handshake.
REQ-015 rdata  output  8  latched bus value; feeds accumulator memory-read write port.
REQ-016 stall  output  1  1 while an access is in flight; gates CPU stepping.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 timeout  output  1  one-cycle pulse on forced completion (macro-dependent).

Function
REQ-019 FSM states IDLE, ACCESS, DONE, encoded as registered state.
REQ-020 IDLE: req=1 and cpu_en=1 at a posedge captures addr/we/wdata into mem_addr/we flag/mem_wdata and enters ACCESS; otherwise stays IDLE.
REQ-021 IDLE with req=1, cpu_en=0: request ignored, no output change.
REQ-022 ACCESS: mem_re=~we_q, mem_we=we_q, both registered, asserted from the first ACCESS cycle; never both 1.
REQ-023 ACCESS with mem_ready=1: read captures mem_rdata into rdata, write loads mem_wdata into rdata (open-bus value); next state DONE.
REQ-024 Minimum latency: req sampled cycle N, ACCESS cycle N+1, done=1 cycle N+2 if mem_ready=1 in N+1.
REQ-025 ACCESS with mem_ready=0: remain in ACCESS, strobes, mem_addr, mem_wdata held stable.
REQ-026 DONE: done=1, strobes 0, stall=0, next state IDLE unconditionally; req during DONE ignored.
REQ-027 stall=1 exactly when state is ACCESS; combinational from state only.
REQ-028 req, we, addr, wdata changes while not IDLE have no effect.
REQ-029 rdata holds its value in all cycles not covered by REQ-023 or REQ-033.
REQ-030 cpu_en does not affect ACCESS or DONE progress.

Reset
REQ-031 reset=0 at posedge: state IDLE, mem_addr 16'h0000, mem_wdata 8'h00, mem_re 0, mem_we 0, rdata 8'h00, done 0, timeout 0, wait counter 0.
REQ-032 reset=0 during ACCESS aborts the access: strobes are 0 from the following cycle, no done pulse, rdata forced to 8'h00.

Configuration
REQ-033 Macro BUS_TIMEOUT_EN defined: an 8-bit counter, cleared on ACCESS entry, increments each ACCESS cycle with mem_ready=0; on the TIMEOUT-th such cycle the FSM goes to DONE with rdata unchanged, and timeout=1 coincident with done; mem_ready=1 in the same cycle takes priority (normal completion, timeout=0).
REQ-034 Macro BUS_TIMEOUT_EN undefined: no counter, ACCESS waits indefinitely for mem_ready, timeout tied 0.

Verification
REQ-035 Read, zero wait: reset, req=1 we=0 addr=16'h8000, mem_ready=1 with mem_rdata=8'hA9 -> mem_re 1 cycle, done cycle N+2, rdata=8'hA9, stall 1 cycle.
REQ-036 Write, 3 wait cycles: we=1 addr=16'h2006 wdata=8'h3F, mem_ready low 3 cycles -> mem_we held 4 cycles, mem_addr stable, rdata=8'h3F after done.
REQ-037 Request gating: req=1 with cpu_en=0 for 5 cycles -> state IDLE, no strobes; then cpu_en=1 -> access starts next cycle.
REQ-038 Timeout (BUS_TIMEOUT_EN, TIMEOUT=8): prior rdata=8'h55, read never ready -> done and timeout pulse after 8 ACCESS cycles, rdata=8'h55; same run without macro -> stall stays 1.
REQ-039 Reset mid-access: reset=0 on 2nd ACCESS cycle -> strobes 0, rdata 8'h00, no done pulse, IDLE afterwards.
REQ-040 Back-to-back: req held high across two accesses -> second ACCESS begins the cycle after DONE-to-IDLE, never during DONE.

Source files
------------

// File: rtl/cpu_bus_if_if.sv
// Bus bundle between the CPU control unit, the cpu_bus_if bridge and the
// memory map. The bridge connects through the slave modport. The CPU and
// memory environment connect through the master modport.
interface cpu_bus_if_if;
    // CPU side
    logic        cpu_en;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        stall;
    logic        done;
    logic        timeout;
    // memory side
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        mem_ready;

    modport slave (
        input  cpu_en, req, we, addr, wdata, mem_rdata, mem_ready,
        output mem_addr, mem_wdata, mem_re, mem_we, rdata, stall, done, timeout
    );

    modport master (
        output cpu_en, req, we, addr, wdata, mem_rdata, mem_ready,
        input  mem_addr, mem_wdata, mem_re, mem_we, rdata, stall, done, timeout
    );
endinterface

// File: rtl/cpu_bus_if.sv
// cpu_bus_if: bridges single-cycle CPU bus requests onto a memory map that
// answers with a ready handshake. The bridge has three states:
// IDLE, then ACCESS (strobes held until mem_ready), then DONE (one-cycle done pulse).
// Optional feature: define BUS_TIMEOUT_EN to force completion after TIMEOUT
// unanswered ACCESS cycles. In that case a timeout pulse is raised and rdata is left untouched.
module cpu_bus_if #(
    parameter int TIMEOUT = 8   // 1..255
) (
    input  logic         clk,
    input  logic         reset,  // synchronous, active-low
    cpu_bus_if_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state;
    state_t      state_next;

    logic        we_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        re_q;
    logic        wr_q;
    logic [7:0]  rdata_q;
    logic        done_q;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    logic [7:0]  wait_cnt;
    logic        timeout_q;
    logic        expire;
`endif

    // Next-state decode. CPU inputs only matter in IDLE. cpu_en only gates new requests.
    always_comb begin
        state_next = state;
`ifdef BUS_TIMEOUT_EN
        expire = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.req && bus.cpu_en) state_next = ACCESS;
            end
            ACCESS: begin
                if (bus.mem_ready) begin
                    state_next = DONE;
                end
`ifdef BUS_TIMEOUT_EN
                else if (wait_cnt == WAIT_LAST) begin
                    state_next = DONE;
                    expire     = 1'b1;
                end
`endif
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Request capture, strobe generation and read-data latching
    always_ff @(posedge clk) begin
        if (!reset) begin
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            re_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state == ACCESS) && (state_next == DONE);
            case (state)
                IDLE: begin
                    if (state_next == ACCESS) begin
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        we_q    <= bus.we;
                        re_q    <= ~bus.we;
                        wr_q    <= bus.we;
                    end
                end
                ACCESS: begin
                    if (state_next == DONE) begin
                        re_q <= 1'b0;
                        wr_q <= 1'b0;
                        // a write leaves its own data on the bus (open-bus value)
                        if (bus.mem_ready) rdata_q <= we_q ? wdata_q : bus.mem_rdata;
                    end
                end
                default: begin
                    re_q <= 1'b0;
                    wr_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUS_TIMEOUT_EN
    // Wait counter: cleared on ACCESS entry, counts unanswered ACCESS cycles
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt  <= 8'h00;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= expire;
            if (state == IDLE && state_next == ACCESS) wait_cnt <= 8'h00;
            else if (state == ACCESS && !bus.mem_ready) wait_cnt <= wait_cnt + 8'h01;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_re    = re_q;
    assign bus.mem_we    = wr_q;
    assign bus.rdata     = rdata_q;
    assign bus.done      = done_q;
    assign bus.stall     = (state == ACCESS);

endmodule

// File: tb/tb_cpu_bus_if.sv
// Bench for cpu_bus_if. Transactions are built from randomised parameters.
// For each transaction, the expected strobes, latency and rdata are derived
// from that transaction's parameters.
module tb_cpu_bus_if;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    // expected architectural state
    logic [7:0]  rdata_m = 8'h00;
    logic [15:0] addr_m  = 16'h0000;
    logic [7:0]  wdata_m = 8'h00;

    cpu_bus_if_if bus();

    cpu_bus_if #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_cpu();
        bus.req    = 1'($urandom_range(0, 1));
        bus.cpu_en = 1'($urandom_range(0, 1));
        bus.we     = 1'($urandom_range(0, 1));
        bus.addr   = 16'($urandom);
        bus.wdata  = 8'($urandom);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_stall"}, bus.stall, 0);
        chk({tag, "_re"},    bus.mem_re, 0);
        chk({tag, "_we"},    bus.mem_we, 0);
        chk({tag, "_done"},  bus.done, 0);
        chk({tag, "_addr"},  bus.mem_addr, addr_m);
        chk({tag, "_rdata"}, bus.rdata, rdata_m);
    endtask

    // One complete access: the request, then `waits` not-ready cycles, then completion, then the return to IDLE.
    task automatic do_access(input logic w, input logic [15:0] a, input logic [7:0] d,
                             input int waits, input logic [7:0] md);
        bus.req = 1'b1; bus.cpu_en = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
        bus.mem_ready = 1'b0;
        tick();
        addr_m = a; wdata_m = d;
        for (int i = 0; i <= waits; i++) begin
            chk("acc_stall", bus.stall, 1);
            chk("acc_re",    bus.mem_re, !w);
            chk("acc_we",    bus.mem_we, w);
            chk("acc_addr",  bus.mem_addr, addr_m);
            chk("acc_wdata", bus.mem_wdata, wdata_m);
            chk("acc_done",  bus.done, 0);
            chk("acc_rdata", bus.rdata, rdata_m);
            scramble_cpu();
            bus.mem_rdata = 8'($urandom);
            if (i == waits) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = md;
            end
            tick();
        end
        rdata_m = w ? d : md;
        chk("cmp_done",    bus.done, 1);
        chk("cmp_stall",   bus.stall, 0);
        chk("cmp_re",      bus.mem_re, 0);
        chk("cmp_we",      bus.mem_we, 0);
        chk("cmp_rdata",   bus.rdata, rdata_m);
        chk("cmp_timeout", bus.timeout, 0);
        // a request during DONE must be ignored
        bus.mem_ready = 1'b0;
        bus.req = 1'b1; bus.cpu_en = 1'b1;
        bus.addr = 16'($urandom);
        tick();
        bus.req = 1'b0;
        check_idle("post");
    endtask

    // Requests with cpu_en low must never start an access.
    task automatic gated(input int n);
        for (int i = 0; i < n; i++) begin
            bus.req = 1'b1; bus.cpu_en = 1'b0;
            bus.we = 1'($urandom_range(0, 1));
            bus.addr = 16'($urandom); bus.wdata = 8'($urandom);
            tick();
            check_idle("gate");
        end
    endtask

    initial begin
        bus.cpu_en = 1'b0; bus.req = 1'b0; bus.we = 1'b0; bus.addr = 16'h0;
        bus.wdata = 8'h0; bus.mem_rdata = 8'h0; bus.mem_ready = 1'b0;
        reset = 1'b0;
        tick(); tick();
        chk("rst_addr",    bus.mem_addr, 16'h0000);
        chk("rst_wdata",   bus.mem_wdata, 8'h00);
        chk("rst_re",      bus.mem_re, 0);
        chk("rst_we",      bus.mem_we, 0);
        chk("rst_rdata",   bus.rdata, 8'h00);
        chk("rst_done",    bus.done, 0);
        chk("rst_timeout", bus.timeout, 0);
        chk("rst_stall",   bus.stall, 0);
        reset = 1'b1;
        tick();

        // zero-wait read
        do_access(1'b0, 16'h8000, 8'h00, 0, 8'hA9);
        // write with three wait cycles
        do_access(1'b1, 16'h2006, 8'h3F, 3, 8'h00);
        // gating, then the access starts on the first enabled edge
        gated(5);
        do_access(1'b0, 16'h1234, 8'h00, 1, 8'h5A);

        // randomised traffic
        for (int t = 0; t < 40; t++) begin
            gated($urandom_range(0, 2));
            do_access(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                      $urandom_range(0, 5), 8'($urandom));
        end

        // back-to-back: with req held high, each access takes three cycles
        bus.req = 1'b1; bus.cpu_en = 1'b1; bus.we = 1'b0; bus.addr = 16'h4000;
        bus.mem_ready = 1'b1; bus.mem_rdata = 8'hC3;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("b2b_stall", bus.stall, (k % 3) == 0);
            chk("b2b_done",  bus.done,  (k % 3) == 1);
            chk("b2b_re",    bus.mem_re, (k % 3) == 0);
        end
        bus.req = 1'b0; bus.mem_ready = 1'b0;
        tick();
        rdata_m = 8'hC3; addr_m = 16'h4000;
        check_idle("b2b_end");

        // reset on the second ACCESS cycle aborts the access
        bus.req = 1'b1; bus.cpu_en = 1'b1; bus.we = 1'b0; bus.addr = 16'h0F0F;
        tick();
        bus.req = 1'b0;
        tick();
        chk("abort_pre_stall", bus.stall, 1);
        reset = 1'b0;
        tick();
        chk("abort_re",    bus.mem_re, 0);
        chk("abort_we",    bus.mem_we, 0);
        chk("abort_rdata", bus.rdata, 8'h00);
        chk("abort_done",  bus.done, 0);
        chk("abort_stall", bus.stall, 0);
        reset = 1'b1;
        tick();
        chk("abort_after_done",  bus.done, 0);
        chk("abort_after_stall", bus.stall, 0);
        rdata_m = 8'h00;

        // the memory never answers; first leave 8'h55 on the bus with a write
        do_access(1'b1, 16'h0100, 8'h55, 0, 8'h00);
        bus.req = 1'b1; bus.cpu_en = 1'b1; bus.we = 1'b0; bus.addr = 16'h0200;
        bus.mem_ready = 1'b0;
        tick();
        bus.req = 1'b0;
`ifdef BUS_TIMEOUT_EN
        for (int k = 1; k < TO; k++) begin
            chk("to_wait_stall", bus.stall, 1);
            chk("to_wait_done",  bus.done, 0);
            tick();
        end
        chk("to_wait_last", bus.stall, 1);
        tick();
        chk("to_done",    bus.done, 1);
        chk("to_timeout", bus.timeout, 1);
        chk("to_rdata",   bus.rdata, 8'h55);
        chk("to_re",      bus.mem_re, 0);
        tick();
        chk("to_done_end",    bus.done, 0);
        chk("to_timeout_end", bus.timeout, 0);
`else
        for (int k = 0; k < 3 * TO; k++) begin
            chk("hang_stall",   bus.stall, 1);
            chk("hang_re",      bus.mem_re, 1);
            chk("hang_timeout", bus.timeout, 0);
            tick();
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("hang_rst_stall", bus.stall, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
